// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared definitions for the RPi/DE0-Nano byte-link framer
//                and parser: byte width, default SYNC value, framer state
//                encoding and the checksum folding rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    // Framer state encoding, shared with the receiving parser
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_TYPE = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_CHK  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        S_SYNC = ST_SYNC,
        S_TYPE = ST_TYPE,
        S_LEN  = ST_LEN,
        S_DATA = ST_DATA,
        S_CHK  = ST_CHK
    } state_e;

    // Checksum is the XOR of TYPE, LEN and every payload byte
    function automatic logic [BYTE_W-1:0] chk_fold(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] b
    );
        return acc ^ b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_fsm_if
//  Description : 8-bit valid/ready byte stream between the framer (master)
//                and the downstream consumer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface out_fsm_if;
    import frame_pkg::*;

    logic [BYTE_W-1:0] o_stream;
    logic              o_valid;
    logic              i_ready;

    modport master (output o_stream, output o_valid, input  i_ready);
    modport slave  (input  o_stream, input  o_valid, output i_ready);

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous byte FIFO, DEPTH x 8, with asynchronous head
//                read, registered full flag and count/empty outputs.
//                Writes while full are dropped; a pop and a push in the same
//                cycle are both honoured.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import frame_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_a,
    input  wire logic [BYTE_W-1:0]      i_data,
    input  wire logic                   i_wr,
    input  wire logic                   i_rd,
    output logic      [BYTE_W-1:0]      o_head,
    output logic      [$clog2(DEPTH):0] o_count,
    output logic                        o_full,
    output logic                        o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q;
    logic              w_push, w_pop;

    assign w_push  = i_wr && !full_q;
    assign w_pop   = i_rd && (count_q != '0);
    assign count_d = count_q + CW'(w_push) - CW'(w_pop);

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = full_q;
    assign o_empty = (count_q == '0);

    // Storage array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

endmodule
`default_nettype wire

// File: rtl/out_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : out_fsm
//  Description : Frame transmitter. Queues payload bytes in a FIFO and, on a
//                send request, serialises SYNC, TYPE, LEN, payload, CHK onto
//                a valid/ready byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_fsm
    import frame_pkg::*;
#(
    parameter int                DEPTH = 16,
    parameter logic [BYTE_W-1:0] SYNC  = SYNC_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst_a,
    input  wire logic [BYTE_W-1:0] i_data,
    input  wire logic              i_wr,
    output logic                   o_full,
    input  wire logic [BYTE_W-1:0] i_type,
    input  wire logic              i_send,
    output logic                   o_busy,
    output logic                   o_done,
    out_fsm_if.master              sbus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] type_q, type_d;
    logic [BYTE_W-1:0] len_q,  len_d;
    logic [BYTE_W-1:0] chk_q,  chk_d;
    logic [BYTE_W-1:0] rem_q,  rem_d;
    logic              done_q, done_d;

    logic [BYTE_W-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic [BYTE_W-1:0] w_count8;
    logic              w_empty;
    logic              w_pop;
    logic              w_valid;
    logic              w_hs;
    logic [BYTE_W-1:0] w_stream;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_a   (rst_a),
        .i_data  (i_data),
        .i_wr    (i_wr),
        .i_rd    (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (o_full),
        .o_empty (w_empty)
    );

    // Count is sampled from the register, so a same-cycle write is excluded
    assign w_count8 = BYTE_W'(w_count);
    assign w_hs     = w_valid && sbus.i_ready;

    assign sbus.o_valid  = w_valid;
    assign sbus.o_stream = w_stream;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;

    // State and frame descriptor registers
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= IDLE;
            type_q  <= '0;
            len_q   <= '0;
            chk_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: every non-idle state advances only on a handshake
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        len_d   = len_q;
        chk_d   = chk_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        w_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_send) begin
                    type_d  = i_type;
                    len_d   = w_count8;
                    rem_d   = w_count8;
                    chk_d   = chk_fold(i_type, w_count8);
                    state_d = S_SYNC;
                end
            end
            S_SYNC: if (w_hs) state_d = S_TYPE;
            S_TYPE: if (w_hs) state_d = S_LEN;
            S_LEN: begin
                if (w_hs) state_d = (len_q == '0) ? S_CHK : S_DATA;
            end
            S_DATA: begin
                if (w_hs) begin
                    w_pop = !w_empty;
                    chk_d = chk_fold(chk_q, w_head);
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 8'd1) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (w_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream byte decoded purely from registered state and FIFO contents
    always_comb begin
        w_valid  = (state_q != IDLE);
        w_stream = '0;
        case (state_q)
            S_SYNC:  w_stream = SYNC;
            S_TYPE:  w_stream = type_q;
            S_LEN:   w_stream = len_q;
            S_DATA:  w_stream = w_head;
            S_CHK:   w_stream = chk_q;
            default: w_stream = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_out_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_fsm
//  Description : Self-checking bench for out_fsm; expected stream bytes are
//                queued when a frame is requested and popped on handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_fsm;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [7:0] i_data;
    logic       i_wr;
    logic [7:0] i_type;
    logic       i_send;
    logic       o_full;
    logic       o_busy;
    logic       o_done;

    out_fsm_if sif ();

    out_fsm #(.DEPTH(DEPTH), .SYNC(8'hA5)) dut (
        .clk    (clk),
        .rst_a  (rst_a),
        .i_data (i_data),
        .i_wr   (i_wr),
        .o_full (o_full),
        .i_type (i_type),
        .i_send (i_send),
        .o_busy (o_busy),
        .o_done (o_done),
        .sbus   (sif)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         valid_cycles = 0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_stall = 1'b0;
    logic [7:0] eb;

    // Scoreboard monitor: pops one expected byte per handshake and checks
    // that a stalled byte is held stable into the next cycle
    always @(negedge clk) begin
        if (rst_a) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (sif.o_valid !== 1'b1 || sif.o_stream !== prev_byte) begin
                    errors++;
                    $display("FAIL hold: valid=%b stream=%h required valid=1 stream=%h",
                             sif.o_valid, sif.o_stream, prev_byte);
                end
            end
            if (sif.o_valid === 1'b1) valid_cycles++;
            if (sif.o_valid === 1'b1 && sif.i_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got %h required no byte", sif.o_stream);
                end else begin
                    eb = exp_q.pop_front();
                    if (sif.o_stream !== eb) begin
                        errors++;
                        $display("FAIL stream_byte: got %h required %h", sif.o_stream, eb);
                    end
                end
            end
            prev_stall = (sif.o_valid === 1'b1) && (sif.i_ready !== 1'b1);
            prev_byte  = sif.o_stream;
        end
    end

    task automatic wr_byte(input logic [7:0] d);
        i_data = d;
        i_wr   = 1'b1;
        @(posedge clk); #1;
        i_wr   = 1'b0;
    endtask

    task automatic send(input logic [7:0] t);
        i_type = t;
        i_send = 1'b1;
        @(posedge clk); #1;
        i_send = 1'b0;
    endtask

    // Waits for o_done at negedges; ends sampled at the negedge of the pulse
    task automatic wait_done(input int budget, input bit toggle, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) got = 1'b1;
            else if (toggle) begin
                @(posedge clk); #1;
                sif.i_ready = ~sif.i_ready;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", sif.o_valid); end
        checks++;
        if (sif.o_stream !== 8'h00) begin errors++; $display("FAIL reset_stream: got %h required 00", sif.o_stream); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
        checks++;
        if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", o_full); end
        checks++;
        if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", o_done); end
    endtask

    task automatic test_basic();
        bit got;
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        exp_q = '{8'hA5, 8'h3C, 8'h03, 8'h01, 8'h02, 8'h03, 8'h3F};
        sif.i_ready  = 1'b1;
        valid_cycles = 0;
        send(8'h3C);
        wait_done(20, 1'b0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL basic_done: got timeout required o_done"); end
        checks++;
        if (valid_cycles != 7) begin errors++; $display("FAIL basic_len: got %0d valid cycles required 7", valid_cycles); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d bytes unsent required 0", exp_q.size()); end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got o_done %b required 0", o_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        bit got;
        exp_q = '{8'hA5, 8'h7E, 8'h00, 8'h7E};
        valid_cycles = 0;
        send(8'h7E);
        wait_done(20, 1'b0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL empty_done: got timeout required o_done"); end
        checks++;
        if (valid_cycles != 4) begin errors++; $display("FAIL empty_len: got %0d valid cycles required 4", valid_cycles); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL empty_left: got %0d bytes unsent required 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        bit got;
        for (int i = 0; i < 15; i++) wr_byte(8'(i));
        checks++;
        if (o_full !== 1'b0) begin errors++; $display("FAIL ovf_not_full: got %b required 0", o_full); end
        wr_byte(8'h0F);
        checks++;
        if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b required 1", o_full); end
        wr_byte(8'h10);
        exp_q = '{8'hA5, 8'h11, 8'h10};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h01);
        valid_cycles = 0;
        send(8'h11);
        wait_done(40, 1'b0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL ovf_done: got timeout required o_done"); end
        checks++;
        if (valid_cycles != 20) begin errors++; $display("FAIL ovf_len: got %0d valid cycles required 20", valid_cycles); end
        checks++;
        if (o_full !== 1'b0) begin errors++; $display("FAIL ovf_drained: got full %b required 0", o_full); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        bit got;
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        exp_q = '{8'hA5, 8'h3C, 8'h03, 8'h01, 8'h02, 8'h03, 8'h3F};
        sif.i_ready  = 1'b0;
        valid_cycles = 0;
        send(8'h3C);
        wait_done(40, 1'b1, got);
        checks++;
        if (!got) begin errors++; $display("FAIL bp_done: got timeout required o_done"); end
        checks++;
        if (valid_cycles != 14) begin errors++; $display("FAIL bp_len: got %0d valid cycles required 14", valid_cycles); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left: got %0d bytes unsent required 0", exp_q.size()); end
        @(posedge clk); #1;
        sif.i_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit got;
        wr_byte(8'h01); wr_byte(8'h02);
        exp_q = '{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'h5B};
        // Send cycle also writes AA, which must not count toward this frame
        i_type = 8'h5A; i_send = 1'b1; i_data = 8'hAA; i_wr = 1'b1;
        @(posedge clk); #1;
        i_send = 1'b0; i_wr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL ovl_busy: got %b required 1", o_busy); end
        // Mid-frame write plus an ignored send request
        i_type = 8'h99; i_send = 1'b1; i_data = 8'hBB; i_wr = 1'b1;
        @(posedge clk); #1;
        i_send = 1'b0; i_wr = 1'b0;
        wait_done(20, 1'b0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL ovl_done1: got timeout required o_done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovl_left1: got %0d bytes unsent required 0", exp_q.size()); end
        @(posedge clk); #1;
        exp_q = '{8'hA5, 8'h33, 8'h02, 8'hAA, 8'hBB, 8'h20};
        send(8'h33);
        wait_done(20, 1'b0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL ovl_done2: got timeout required o_done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovl_left2: got %0d bytes unsent required 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit got;
        for (int i = 1; i <= 4; i++) wr_byte(8'(i));
        exp_q = '{8'hA5, 8'h44, 8'h04, 8'h01};
        send(8'h44);
        repeat (4) begin @(posedge clk); #1; end
        rst_a = 1'b1;
        #1;
        checks++;
        if (sif.o_valid !== 1'b0 || sif.o_stream !== 8'h00) begin
            errors++;
            $display("FAIL midrst_stream: got valid=%b stream=%h required valid=0 stream=00", sif.o_valid, sif.o_stream);
        end
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags: got busy=%b done=%b full=%b required 0 0 0", o_busy, o_done, o_full);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_seen: got %0d bytes unsent required 0", exp_q.size()); end
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(posedge clk); #1;
        exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        valid_cycles = 0;
        send(8'h00);
        wait_done(20, 1'b0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL midrst_done: got timeout required o_done"); end
        checks++;
        if (valid_cycles != 4) begin errors++; $display("FAIL midrst_len: got %0d valid cycles required 4", valid_cycles); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_left: got %0d bytes unsent required 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_a = 1'b1;
        i_data = 8'h00; i_wr = 1'b0; i_type = 8'h00; i_send = 1'b0;
        sif.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_a = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_empty();
        test_overflow();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
